axis64_ingress_pkt_fifo: RTL and testbench

//  Store-and-forward AXI-Stream packet buffer in front of from_net_* of the KVS block diagram.

---
 rtl/axis64_ingress_pkt_fifo.sv | 196 +++++++++++++++++++
 tb/tb_axis64_ingress_pkt_fifo.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis64_ingress_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO on the 390 MHz network clock. Ingress never stalls;
// only fully committed packets reach m_*, and a packet that cannot fit is dropped as a whole.
module axis64_ingress_pkt_fifo #(
    parameter int DEPTH    = 512,
    parameter int MAX_PKTS = 32,
    localparam int AW      = $clog2(DEPTH),
    localparam int PW      = $clog2(MAX_PKTS)
) (
    input  logic          clk_390,
    input  logic          clk_390_rst_n,
    input  logic [63:0]   s_tdata,
    input  logic [7:0]    s_tkeep,
    input  logic [63:0]   s_tuser,
    input  logic          s_tlast,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [63:0]   m_tdata,
    output logic [7:0]    m_tkeep,
    output logic [63:0]   m_tuser,
    output logic          m_tlast,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [31:0]   drop_cnt,
    output logic [PW:0]   pkt_cnt
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both 1; valid and
    // payload are held unchanged until that happens, and ready may change at any time.

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [PW:0] MAX_W   = (PW + 1)'(MAX_PKTS);

    typedef enum logic {
        WR_PASS = 1'b0,
        WR_DROP = 1'b1
    } wr_state_t;

    logic [72:0] mem [DEPTH];
    logic [63:0] meta_mem [MAX_PKTS];

    wr_state_t   wr_state, wr_state_nx;
    logic [AW:0] wr_ptr, wr_ptr_nx, commit_ptr, commit_ptr_nx, rd_ptr, used;
    logic [PW-1:0] meta_wr, meta_rd;
    logic        beat, space, meta_full, wr_en, commit, drop;

    assign beat      = s_tvalid & s_tready;
    assign used      = wr_ptr - rd_ptr;
    assign space     = used < DEPTH_W;
    // Every packet still occupies a metadata slot until its m_tlast handshake.
    assign meta_full = (pkt_cnt == MAX_W);

    always_comb begin
        wr_state_nx   = wr_state;
        wr_ptr_nx     = wr_ptr;
        commit_ptr_nx = commit_ptr;
        wr_en         = 1'b0;
        commit        = 1'b0;
        drop          = 1'b0;
        if (beat) begin
            case (wr_state)
                WR_PASS: begin
                    if (space) begin
                        wr_en     = 1'b1;
                        wr_ptr_nx = wr_ptr + 1'b1;
                    end
                    if (s_tlast) begin
                        if (space && !meta_full) begin
                            commit        = 1'b1;
                            commit_ptr_nx = wr_ptr + 1'b1;
                        end else begin
                            drop      = 1'b1;
                            wr_ptr_nx = commit_ptr;
                        end
                    end else if (!space) begin
                        drop        = 1'b1;
                        wr_ptr_nx   = commit_ptr;
                        wr_state_nx = WR_DROP;
                    end
                end
                WR_DROP: begin
                    if (s_tlast) begin
                        wr_state_nx = WR_PASS;
                    end
                end
                default: wr_state_nx = WR_PASS;
            endcase
        end
    end

    always_ff @(posedge clk_390) begin
        if (!clk_390_rst_n) begin
            wr_state   <= WR_PASS;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            meta_wr    <= '0;
            drop_cnt   <= '0;
            s_tready   <= 1'b0;
        end else begin
            wr_state   <= wr_state_nx;
            wr_ptr     <= wr_ptr_nx;
            commit_ptr <= commit_ptr_nx;
            s_tready   <= 1'b1;
            if (commit) begin
                meta_wr <= meta_wr + 1'b1;
            end
            if (drop && (drop_cnt != 32'hFFFF_FFFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_390) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tkeep, s_tdata};
        end
        if (commit) begin
            meta_mem[meta_wr] <= s_tuser;
        end
    end

    // Read side: RAM output stage, prefetch word and output register hold at most two words
    // between them, so a read is issued only when the word it returns is sure to find a slot.
    logic [72:0] ram_q, pf_q, load_word;
    logic [1:0]  occ;
    logic        pop, out_free, rd_en, ram_vld, pf_vld, load, next_first;

    assign pop      = m_tvalid & m_tready;
    assign out_free = !m_tvalid | m_tready;
    assign occ      = {1'b0, m_tvalid} + {1'b0, pf_vld} + {1'b0, ram_vld};
    assign rd_en    = (rd_ptr != commit_ptr) && ((occ - {1'b0, pop}) < 2'd2);

    always_comb begin
        load      = 1'b0;
        load_word = ram_q;
        if (out_free) begin
            if (pf_vld) begin
                load      = 1'b1;
                load_word = pf_q;
            end else if (ram_vld) begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_390) begin
        if (rd_en) begin
            ram_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk_390) begin
        if (!clk_390_rst_n) begin
            rd_ptr     <= '0;
            ram_vld    <= 1'b0;
            pf_vld     <= 1'b0;
            pf_q       <= '0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tlast    <= 1'b0;
            m_tuser    <= '0;
            meta_rd    <= '0;
            next_first <= 1'b1;
            pkt_cnt    <= '0;
        end else begin
            ram_vld <= rd_en;
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (load) begin
                m_tvalid                    <= 1'b1;
                {m_tlast, m_tkeep, m_tdata} <= load_word;
                next_first                  <= load_word[72];
                if (next_first) begin
                    m_tuser <= meta_mem[meta_rd];
                    meta_rd <= meta_rd + 1'b1;
                end
            end else if (pop) begin
                m_tvalid <= 1'b0;
            end
            // A returning RAM word parks in the prefetch slot unless it goes straight out.
            if (ram_vld && (pf_vld || !out_free)) begin
                pf_q   <= ram_q;
                pf_vld <= 1'b1;
            end else if (out_free) begin
                pf_vld <= 1'b0;
            end
            case ({commit, pop & m_tlast})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_axis64_ingress_pkt_fifo.sv
// Directed bench for axis64_ingress_pkt_fifo with a small buffer (16 words, 4 packets) so that
// overflow, metadata-full and pointer wrap-around are all reachable in a short run.
`timescale 1ns/1ps
module tb_axis64_ingress_pkt_fifo;

    localparam int DEPTH    = 16;
    localparam int MAX_PKTS = 4;
    localparam int PW       = 2;
    localparam int BW       = 137;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   s_tdata, s_tuser, m_tdata, m_tuser;
    logic [7:0]    s_tkeep, m_tkeep;
    logic          s_tlast, s_tvalid, s_tready;
    logic          m_tlast, m_tvalid, m_tready;
    logic [31:0]   drop_cnt;
    logic [PW:0]   pkt_cnt;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] obs_q[$];
    int            obs_cyc[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            stall_err = 0;
    int            rdy_mode = 0;
    logic          rdy_fixed = 1'b0;
    logic          stall_prev = 1'b0;
    logic [BW-1:0] stall_word;

    axis64_ingress_pkt_fifo #(.DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS)) dut (
        .clk_390(clk), .clk_390_rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt)
    );

    // Clock, cycle counter and watchdog
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Egress ready driver: fixed level, 1010 toggle or random
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       m_tready = ~m_tready;
                2:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = rdy_fixed;
            endcase
        end
    end

    // Egress monitor: records accepted beats and counts payload changes during stalls
    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (m_tvalid !== 1'b1 || {m_tuser, m_tlast, m_tkeep, m_tdata} !== stall_word))
                stall_err++;
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                obs_q.push_back({m_tuser, m_tlast, m_tkeep, m_tdata});
                obs_cyc.push_back(cyc);
            end
            stall_prev = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
            stall_word = {m_tuser, m_tlast, m_tkeep, m_tdata};
        end
    end

    // Driver tasks: entered and left 1 ns after a rising edge
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic [63:0] u,
                              input logic l);
        s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic apply_reset();
        s_tvalid = 1'b0;
        rst_n    = 1'b0;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(2);
        clear_sb();
    endtask

    task automatic test_reset();
        s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        rst_n = 1'b0;
        idle_cycles(3);
        // a beat offered during reset must be ignored
        drive_beat(64'h1234, 8'hFF, 64'h99, 1'b1);
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s_tready: got %b expected 0", s_tready); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_m_tlast: got %b expected 0", m_tlast); end
        n_checks++; if (m_tdata !== 64'h0) begin n_fail++; $display("FAIL rst_m_tdata: got %h expected 0", m_tdata); end
        n_checks++; if (m_tkeep !== 8'h0) begin n_fail++; $display("FAIL rst_m_tkeep: got %h expected 0", m_tkeep); end
        n_checks++; if (m_tuser !== 64'h0) begin n_fail++; $display("FAIL rst_m_tuser: got %h expected 0", m_tuser); end
        n_checks++; if (drop_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_drop_cnt: got %0d expected 0", drop_cnt); end
        n_checks++; if (pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_pkt_cnt: got %0d expected 0", pkt_cnt); end
        s_tvalid = 1'b0;
        rst_n    = 1'b1;
        idle_cycles(5);
        n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_s_tready: got %b expected 1", s_tready); end
        n_checks++; if (pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_release_pkt_cnt: got %0d expected 0", pkt_cnt); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_release_m_tvalid: got %b expected 0", m_tvalid); end
        clear_sb();
    endtask

    task automatic test_single_pkt();
        logic [7:0] keeps [3];
        keeps = '{8'hFF, 8'hFF, 8'h0F};
        rdy_mode = 0; rdy_fixed = 1'b1;
        idle_cycles(3);
        clear_sb();
        for (int i = 0; i < 3; i++) begin
            drive_beat(64'hA000_0000_0000_00A0 + 64'(i), keeps[i], (i == 2) ? 64'h55 : 64'hDEAD, i == 2);
            exp_q.push_back({64'h55, (i == 2), keeps[i], 64'hA000_0000_0000_00A0 + 64'(i)});
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_t1: got %b expected 0", m_tvalid); end
        n_checks++; if (pkt_cnt !== 3'd1) begin n_fail++; $display("FAIL t1_pkt_cnt_commit: got %0d expected 1", pkt_cnt); end
        @(negedge clk);
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_t2: got %b expected 0", m_tvalid); end
        @(negedge clk);
        n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL t1_valid_t3: got %b expected 1", m_tvalid); end
        wait_obs(3, 50);
        idle_cycles(3);
        n_checks++; if (pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL t1_pkt_cnt_done: got %0d expected 0", pkt_cnt); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t1_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t1_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int span;
        for (int pass = 0; pass < 2; pass++) begin
            clear_sb();
            stall_err = 0;
            rdy_mode  = pass;
            rdy_fixed = 1'b1;
            idle_cycles(2);
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < 4; b++) begin
                    logic [63:0] d, u;
                    logic [7:0]  k;
                    d = 64'hB000_0000_0000_0000 + 64'(pass * 256 + p * 16 + b);
                    u = 64'hB100 + 64'(pass * 2 + p);
                    k = (b == 3) ? 8'h3F : 8'hFF;
                    drive_beat(d, k, u, b == 3);
                    exp_q.push_back({u, (b == 3), k, d});
                end
            end
            idle_cycles(1);
            wait_obs(8, 200);
            rdy_mode = 0;
            idle_cycles(3);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t2_count[%0d]: got %0d beats expected %0d", pass, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t2_beat[%0d][%0d]: got %h expected %h", pass, i, obs_q[i], exp_q[i]); end
            end
            n_checks++;
            if (stall_err != 0) begin n_fail++; $display("FAIL t2_stall_stable[%0d]: got %0d changes expected 0", pass, stall_err); end
        end
        // first pass ran with m_tready held high: the 8 beats must be on consecutive cycles
        span = -1;
        n_checks++;
        if (rdy_fixed !== 1'b1) begin n_fail++; $display("FAIL t2_ready_level: got %b expected 1", rdy_fixed); end
        clear_sb();
        for (int b = 0; b < 8; b++) begin
            logic [63:0] d;
            d = 64'hB200_0000_0000_0000 + 64'(b);
            drive_beat(d, 8'hFF, 64'hB2 + 64'(b / 4), (b % 4) == 3);
        end
        idle_cycles(1);
        wait_obs(8, 100);
        if (obs_cyc.size() >= 8) span = obs_cyc[7] - obs_cyc[0];
        n_checks++;
        if (span != 7) begin n_fail++; $display("FAIL t2_no_bubble: got span %0d cycles expected 7", span); end
        idle_cycles(3);
    endtask

    task automatic test_overflow();
        rdy_mode = 0; rdy_fixed = 1'b0;
        apply_reset();
        for (int i = 0; i < 20; i++)
            drive_beat(64'h3000_0000_0000_0000 + 64'(i), 8'hFF, 64'h30, i == 19);
        for (int i = 0; i < 4; i++) begin
            drive_beat(64'h3100_0000_0000_0000 + 64'(i), 8'hFF, 64'h31, i == 3);
            exp_q.push_back({64'h31, (i == 3), 8'hFF, 64'h3100_0000_0000_0000 + 64'(i)});
        end
        idle_cycles(5);
        n_checks++; if (drop_cnt !== 32'd1) begin n_fail++; $display("FAIL t3_drop_cnt: got %0d expected 1", drop_cnt); end
        n_checks++; if (pkt_cnt !== 3'd1) begin n_fail++; $display("FAIL t3_pkt_cnt: got %0d expected 1", pkt_cnt); end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL t3_held: got %0d beats expected 0", obs_q.size()); end
        rdy_fixed = 1'b1;
        idle_cycles(20);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t3_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t3_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL t3_pkt_cnt_done: got %0d expected 0", pkt_cnt); end
    endtask

    task automatic test_wrap();
        int tmo = 0;
        rdy_mode = 0; rdy_fixed = 1'b0;
        apply_reset();
        rdy_mode = 2;
        for (int p = 0; p < 50; p++) begin
            int k = 0;
            while (pkt_cnt > 3'd1 && k < 200) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (k >= 200) tmo++;
            for (int b = 0; b < 5; b++) begin
                logic [63:0] d, u;
                logic [7:0]  kp;
                d  = 64'hD000_0000_0000_0000 | (64'(p) << 8) | 64'(b);
                u  = 64'h4000 + 64'(p);
                kp = (b == 4) ? 8'h01 : 8'hFF;
                drive_beat(d, kp, u, b == 4);
                exp_q.push_back({u, (b == 4), kp, d});
            end
            idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(1);
        wait_obs(250, 3000);
        rdy_mode = 0; rdy_fixed = 1'b1;
        idle_cycles(5);
        n_checks++; if (tmo != 0) begin n_fail++; $display("FAIL t4_pacing_timeout: got %0d timeouts expected 0", tmo); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t4_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t4_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL t4_drop_cnt: got %0d expected 0", drop_cnt); end
        n_checks++; if (pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL t4_pkt_cnt: got %0d expected 0", pkt_cnt); end
    endtask

    task automatic test_meta_full();
        rdy_mode = 0; rdy_fixed = 1'b0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_beat(64'h5000 + 64'(i), 8'hFF, 64'h50 + 64'(i), 1'b1);
            if (i < 4) exp_q.push_back({64'h50 + 64'(i), 1'b1, 8'hFF, 64'h5000 + 64'(i)});
        end
        idle_cycles(5);
        n_checks++; if (pkt_cnt !== 3'd4) begin n_fail++; $display("FAIL t5_pkt_cnt: got %0d expected 4", pkt_cnt); end
        n_checks++; if (drop_cnt !== 32'd1) begin n_fail++; $display("FAIL t5_drop_cnt: got %0d expected 1", drop_cnt); end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL t5_held: got %0d beats expected 0", obs_q.size()); end
        rdy_fixed = 1'b1;
        wait_obs(4, 50);
        idle_cycles(5);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t5_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t5_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL t5_pkt_cnt_done: got %0d expected 0", pkt_cnt); end
    endtask

    task automatic test_reset_mid_pkt();
        rdy_mode = 0; rdy_fixed = 1'b1;
        apply_reset();
        drive_beat(64'h6000, 8'hFF, 64'h66, 1'b0);
        drive_beat(64'h6001, 8'hFF, 64'h66, 1'b0);
        rst_n = 1'b0;
        drive_beat(64'h6002, 8'hFF, 64'h66, 1'b0);
        drive_beat(64'h6003, 8'hFF, 64'h66, 1'b0);
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL t6_s_tready_in_reset: got %b expected 0", s_tready); end
        s_tvalid = 1'b0;
        rst_n    = 1'b1;
        idle_cycles(3);
        for (int i = 0; i < 2; i++) begin
            drive_beat(64'h6100 + 64'(i), 8'hFF, 64'h61, i == 1);
            exp_q.push_back({64'h61, (i == 1), 8'hFF, 64'h6100 + 64'(i)});
        end
        idle_cycles(1);
        wait_obs(2, 50);
        idle_cycles(10);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t6_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t6_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL t6_drop_cnt: got %0d expected 0", drop_cnt); end
        n_checks++; if (pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL t6_pkt_cnt: got %0d expected 0", pkt_cnt); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_pkt();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_meta_full();
        test_reset_mid_pkt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
